// File: rtl/traffic_light_ctrl.sv
// Two-road junction sequencer with a pedestrian walk phase; phase timers advance on the
// shared tick. All lamp outputs are flops loaded from the next state, so no input reaches an output combinationally.
module traffic_light_ctrl #(
    parameter int NS_GREEN_MIN = 8,
    parameter int EW_GREEN     = 6,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       sensor_ew,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [2:0] phase
);

    localparam int MAX_A = (NS_GREEN_MIN > EW_GREEN) ? NS_GREEN_MIN : EW_GREEN;
    localparam int MAX_B = (YELLOW_TICKS > ALLRED_TICKS) ? YELLOW_TICKS : ALLRED_TICKS;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_P = (MAX_C > WALK_TICKS) ? MAX_C : WALK_TICKS;
    localparam int TW    = ($clog2(MAX_P) > 1) ? $clog2(MAX_P) : 1;

    typedef enum logic [2:0] {
        S_NS_G = 3'd0,
        S_NS_Y = 3'd1,
        S_AR1  = 3'd2,
        S_EW_G = 3'd3,
        S_EW_Y = 3'd4,
        S_AR2  = 3'd5,
        S_PED  = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ew_pend_q, ew_pend_d;
    logic          ped_pend_q, ped_pend_d;
    logic [6:0]    lamps_q, lamps_d;
    logic          expire_s;

    // Timer value on which the current state's duration runs out.
    function automatic logic [TW-1:0] last_count(input state_t s);
        case (s)
            S_NS_G:  last_count = TW'(NS_GREEN_MIN - 1);
            S_NS_Y:  last_count = TW'(YELLOW_TICKS - 1);
            S_AR1:   last_count = TW'(ALLRED_TICKS - 1);
            S_EW_G:  last_count = TW'(EW_GREEN - 1);
            S_EW_Y:  last_count = TW'(YELLOW_TICKS - 1);
            S_AR2:   last_count = TW'(ALLRED_TICKS - 1);
            S_PED:   last_count = TW'(WALK_TICKS - 1);
            default: last_count = {TW{1'b0}};
        endcase
    endfunction

    // Lamp pattern {ns[2:0], ew[2:0], walk}; unknown encodings show all-red.
    function automatic logic [6:0] decode_lamps(input state_t s);
        case (s)
            S_NS_G:  decode_lamps = 7'b001_100_0;
            S_NS_Y:  decode_lamps = 7'b010_100_0;
            S_EW_G:  decode_lamps = 7'b100_001_0;
            S_EW_Y:  decode_lamps = 7'b100_010_0;
            S_PED:   decode_lamps = 7'b100_100_1;
            default: decode_lamps = 7'b100_100_0;
        endcase
    endfunction

    // Next-state, phase timer and request-latch logic.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        ew_pend_d  = ew_pend_q;
        ped_pend_d = ped_pend_q;
        expire_s   = tick && (timer_q == last_count(state_q));

        case (state_q)
            S_NS_G: begin
                if (expire_s && (ew_pend_q || ped_pend_q)) state_d = S_NS_Y;
                else                                       state_d = S_NS_G;
            end
            S_NS_Y: begin
                if (expire_s) state_d = S_AR1;
                else          state_d = S_NS_Y;
            end
            S_AR1: begin
                if (expire_s) state_d = ew_pend_q ? S_EW_G : S_PED;
                else          state_d = S_AR1;
            end
            S_EW_G: begin
                if (expire_s) state_d = S_EW_Y;
                else          state_d = S_EW_G;
            end
            S_EW_Y: begin
                if (expire_s) state_d = S_AR2;
                else          state_d = S_EW_Y;
            end
            S_AR2: begin
                if (expire_s) state_d = ped_pend_q ? S_PED : S_NS_G;
                else          state_d = S_AR2;
            end
            S_PED: begin
                if (expire_s) state_d = S_NS_G;
                else          state_d = S_PED;
            end
            default: state_d = S_AR2;
        endcase

        // NS green saturates at its last count while nothing is waiting.
        if (state_d != state_q)      timer_d = {TW{1'b0}};
        else if (tick && !expire_s)  timer_d = timer_q + TW'(1);
        else                         timer_d = timer_q;

        // Entering the serving state clears the latch even if the request is still high.
        if (state_d == S_EW_G && state_q != S_EW_G) ew_pend_d = 1'b0;
        else                                        ew_pend_d = ew_pend_q | sensor_ew;

        if (state_d == S_PED && state_q != S_PED) ped_pend_d = 1'b0;
        else                                      ped_pend_d = ped_pend_q | ped_req;

        lamps_d = decode_lamps(state_d);
    end

    // State, timer, request latches and registered lamp outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_AR2;
            timer_q    <= {TW{1'b0}};
            ew_pend_q  <= 1'b0;
            ped_pend_q <= 1'b0;
            lamps_q    <= 7'b100_100_0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ew_pend_q  <= ew_pend_d;
            ped_pend_q <= ped_pend_d;
            lamps_q    <= lamps_d;
        end
    end

    assign ns_light = lamps_q[6:4];
    assign ew_light = lamps_q[3:1];
    assign walk     = lamps_q[0];
    assign phase    = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: a phase/elapsed-tick model checked every cycle,
// plus hand-computed phase durations and reset values.
module tb_traffic_light_ctrl;

    localparam int NSG  = 8;
    localparam int EWG  = 6;
    localparam int YEL  = 4;
    localparam int AR   = 1;
    localparam int WLK  = 5;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       sensor_ew;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [2:0] phase;

    int total = 0;
    int bad   = 0;
    int tick_mode = 0;
    bit chk_en = 1'b0;

    int         dur    [0:6] = '{NSG, YEL, AR, EWG, YEL, AR, WLK};
    logic [2:0] ns_tab [0:6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_tab [0:6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};

    int m_ph;
    int m_cnt;
    bit m_ew;
    bit m_ped;

    traffic_light_ctrl #(
        .NS_GREEN_MIN(NSG),
        .EW_GREEN    (EWG),
        .YELLOW_TICKS(YEL),
        .ALLRED_TICKS(AR),
        .WALK_TICKS  (WLK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .sensor_ew(sensor_ew),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk),
        .phase    (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Junction model: phase number, ticks spent in it, and the two waiting flags.
    always @(posedge clk or negedge rst_n) begin : model_p
        int nxt;
        if (!rst_n) begin
            m_ph  <= 5;
            m_cnt <= 0;
            m_ew  <= 1'b0;
            m_ped <= 1'b0;
        end else begin
            nxt = m_ph;
            if (tick && (m_cnt + 1 >= dur[m_ph])) begin
                case (m_ph)
                    0: nxt = (m_ew || m_ped) ? 1 : 0;
                    1: nxt = 2;
                    2: nxt = m_ew ? 3 : 6;
                    3: nxt = 4;
                    4: nxt = 5;
                    5: nxt = m_ped ? 6 : 0;
                    default: nxt = 0;
                endcase
            end
            m_ph <= nxt;
            if (nxt != m_ph) m_cnt <= 0;
            else if (tick)   m_cnt <= m_cnt + 1;
            m_ew  <= (nxt == 3 && m_ph != 3) ? 1'b0 : (m_ew | sensor_ew);
            m_ped <= (nxt == 6 && m_ph != 6) ? 1'b0 : (m_ped | ped_req);
        end
    end

    // Every-cycle comparison against the model plus the lamp safety rules.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_phase", int'(phase), m_ph);
            chk("model_ns", int'(ns_light), int'(ns_tab[m_ph]));
            chk("model_ew", int'(ew_light), int'(ew_tab[m_ph]));
            chk("model_walk", int'(walk), (m_ph == 6) ? 1 : 0);
            chk("safety_both_nonred", int'(ns_light != 3'b100 && ew_light != 3'b100), 0);
            chk("safety_walk_nonred", int'(walk && (ns_light != 3'b100 || ew_light != 3'b100)), 0);
        end
    end

    // Time base: every cycle, every third cycle, or never.
    initial begin
        int tcnt;
        tcnt = 0;
        tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tick_mode)
                0: tick = 1'b1;
                1: begin
                    tick = (tcnt % 3 == 0);
                    tcnt++;
                end
                default: tick = 1'b0;
            endcase
        end
    end

    task automatic wait_phase(input int p, input int budget, input string name);
        int n;
        n = 0;
        while (int'(phase) != p && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(phase), p);
    endtask

    // From a negedge inside phase p, count ticks consumed until the phase changes.
    task automatic measure(input int p, input int exp_ticks, input int start_n, input string name);
        int n;
        int cyc;
        n = start_n;
        cyc = 0;
        chk({name, "_entry"}, int'(phase), p);
        while (int'(phase) == p && cyc < 200) begin
            n += int'(tick);
            @(negedge clk);
            cyc++;
        end
        chk(name, n, exp_ticks);
    endtask

    task automatic hold_ns_green(input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk(name, int'(phase), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sensor_ew = 1'b0;
        ped_req = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_phase", int'(phase), 5);
        chk("rst_ns", int'(ns_light), 4);
        chk("rst_ew", int'(ew_light), 4);
        chk("rst_walk", int'(walk), 0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_phase", int'(phase), 0);
        chk("rel_ns", int'(ns_light), 1);

        // Idle main road.
        hold_ns_green(40, "idle_phase");
        chk("idle_ew", int'(ew_light), 4);

        // Pedestrian only, from a saturated NS green.
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        measure(0, 1, 0, "ped_nsg");
        measure(1, 4, 0, "ped_nsy");
        measure(2, 1, 0, "ped_ar1");
        chk("ped_walk_on", int'(walk), 1);
        measure(6, 5, 0, "ped_walk");

        // EW demand on tick 2 of a fresh NS green.
        @(negedge clk);
        sensor_ew = 1'b1;
        @(negedge clk);
        sensor_ew = 1'b0;
        measure(0, 8, 2, "ew_nsg");
        measure(1, 4, 0, "ew_nsy");
        measure(2, 1, 0, "ew_ar1");
        measure(3, 6, 0, "ew_ewg");
        measure(4, 4, 0, "ew_ewy");
        measure(5, 1, 0, "ew_ar2");
        chk("ew_back", int'(phase), 0);

        // Both requests in one cycle: EW first, then walk, each served once.
        sensor_ew = 1'b1;
        ped_req = 1'b1;
        @(negedge clk);
        sensor_ew = 1'b0;
        ped_req = 1'b0;
        measure(0, 8, 1, "both_nsg");
        measure(1, 4, 0, "both_nsy");
        measure(2, 1, 0, "both_ar1");
        measure(3, 6, 0, "both_ewg");
        measure(4, 4, 0, "both_ewy");
        measure(5, 1, 0, "both_ar2");
        measure(6, 5, 0, "both_ped");
        hold_ns_green(20, "both_once");

        // Request held through the edge that enters PED is not re-latched.
        ped_req = 1'b1;
        wait_phase(6, 60, "cw_enter");
        ped_req = 1'b0;
        measure(6, 5, 0, "cw_walk");
        hold_ns_green(20, "cw_no_repeat");

        // Sparse ticks: durations still counted in ticks.
        tick_mode = 1;
        sensor_ew = 1'b1;
        @(negedge clk);
        sensor_ew = 1'b0;
        measure(0, 1, 0, "sp_nsg");
        measure(1, 4, 0, "sp_nsy");
        measure(2, 1, 0, "sp_ar1");
        measure(3, 6, 0, "sp_ewg");
        measure(4, 4, 0, "sp_ewy");
        measure(5, 1, 0, "sp_ar2");
        chk("sp_back", int'(phase), 0);
        tick_mode = 0;

        // Asynchronous reset mid EW green drops the pending walk.
        sensor_ew = 1'b1;
        @(negedge clk);
        sensor_ew = 1'b0;
        wait_phase(3, 60, "mr_ewg");
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mr_phase", int'(phase), 5);
        chk("mr_ns", int'(ns_light), 4);
        chk("mr_ew", int'(ew_light), 4);
        chk("mr_walk", int'(walk), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_rel_phase", int'(phase), 0);
        chk("mr_rel_ns", int'(ns_light), 1);
        hold_ns_green(20, "mr_ped_lost");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0t expected < 200000", $time);
        $fatal(1, "timeout");
    end

endmodule
